// File: rtl/log_scan_sequencer.sv
// log_scan_sequencer
//   Sweeps the log-select mux of the loop-diagnostic logger through a
//   programmable set of channels. After each select change it waits out the
//   mux pipeline, then captures `dwell` consecutive samples. Each sample is
//   streamed as one AXI-Stream beat tagged with its channel code.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start, stop           sweep start pulse / abort request
//   continuous            re-run the sweep after the last channel (latched at start)
//   ch_mask, dwell        channel enable mask and samples per channel (latched at start)
//   sel_out               select code driven to the log mux
//   S_AXIS_LOG_tdata      mux output data
//   M_AXIS_*              captured sample stream (tuser = channel, tlast = end of sweep)
//   busy, done, overflow  status: not idle / sweep-complete pulse / sticky sample drop
module log_scan_sequencer #(
  parameter int unsigned NUM_CH  = 18,
  parameter int unsigned SETTLE  = 2,
  parameter int unsigned DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               continuous,
  input  logic [31:0]        ch_mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [4:0]         sel_out,
  input  logic [31:0]        S_AXIS_LOG_tdata,
  output logic [31:0]        M_AXIS_tdata,
  output logic [4:0]         M_AXIS_tuser,
  output logic               M_AXIS_tlast,
  output logic               M_AXIS_tvalid,
  input  logic               M_AXIS_tready,
  output logic               busy,
  output logic               done,
  output logic               overflow
);

  localparam int unsigned SCW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CAPTURE, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [NUM_CH-1:0]   mask_q;
  logic [NUM_CH-1:0]   start_mask;
  logic [DWELL_W-1:0]  dwell_q;
  logic [DWELL_W-1:0]  samp_cnt;
  logic [SCW-1:0]      settle_cnt;
  logic                cont_q;

  logic [4:0]          start_ch, wrap_ch, next_ch;
  logic                next_found;
  logic                accept, capture, last_samp;

  assign start_mask = ch_mask[NUM_CH-1:0];

  generate
    if (NUM_CH < 32) begin : g_unused_mask
      logic unused_mask_hi;
      assign unused_mask_hi = ^ch_mask[31:NUM_CH];
    end
  endgenerate

  // Descending scan so the lowest matching code is the one left standing.
  always_comb begin
    start_ch   = '0;
    wrap_ch    = '0;
    next_ch    = '0;
    next_found = 1'b0;
    for (int unsigned i = NUM_CH; i > 0; i--) begin
      if (start_mask[i-1]) start_ch = 5'(i - 1);
      if (mask_q[i-1])     wrap_ch  = 5'(i - 1);
      if (mask_q[i-1] && (5'(i - 1) > sel_out)) begin
        next_ch    = 5'(i - 1);
        next_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    accept    = 1'b0;
    capture   = 1'b0;
    last_samp = (samp_cnt == dwell_q - DWELL_W'(1));
    if (stop) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            accept  = 1'b1;
            state_d = (start_mask == '0) ? S_DONE : S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (settle_cnt <= SCW'(1)) state_d = S_CAPTURE;
        end
        S_CAPTURE: begin
          capture = 1'b1;
          if (last_samp) state_d = (next_found || cont_q) ? S_SETTLE : S_DONE;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_out       <= '0;
      mask_q        <= '0;
      dwell_q       <= '0;
      cont_q        <= 1'b0;
      samp_cnt      <= '0;
      settle_cnt    <= '0;
      M_AXIS_tdata  <= '0;
      M_AXIS_tuser  <= '0;
      M_AXIS_tlast  <= 1'b0;
      M_AXIS_tvalid <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      if (accept) begin
        mask_q   <= start_mask;
        dwell_q  <= (dwell == '0) ? DWELL_W'(1) : dwell;
        cont_q   <= continuous;
        samp_cnt <= '0;
        overflow <= 1'b0;
        if (start_mask != '0) begin
          sel_out    <= start_ch;
          settle_cnt <= SCW'(SETTLE);
        end
      end

      if (state_q == S_SETTLE && settle_cnt != '0)
        settle_cnt <= settle_cnt - SCW'(1);

      if (capture) begin
        // Schedule always advances; a blocked output only costs the sample.
        if (last_samp) begin
          samp_cnt <= '0;
          if (next_found) begin
            sel_out    <= next_ch;
            settle_cnt <= SCW'(SETTLE);
          end else if (cont_q) begin
            sel_out    <= wrap_ch;
            settle_cnt <= SCW'(SETTLE);
          end
        end else begin
          samp_cnt <= samp_cnt + DWELL_W'(1);
        end

        if (!M_AXIS_tvalid || M_AXIS_tready) begin
          M_AXIS_tdata  <= S_AXIS_LOG_tdata;
          M_AXIS_tuser  <= sel_out;
          M_AXIS_tlast  <= last_samp && !next_found;
          M_AXIS_tvalid <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (M_AXIS_tready) begin
        M_AXIS_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/log_scan_sequencer.md
Name: log_scan_sequencer

Overview:
- Automatic scan controller for the 5-bit log-select mux of the RX/TX loop-diagnostic logger.
- Steps the mux select through a programmable mask of log channels and waits out the mux pipeline latency after each switch.
- Captures a fixed number of consecutive samples per channel.
- Streams each sample as an AXI-Stream beat tagged with its channel, so the DMA/PS side gets a multiplexed snapshot of all loop nodes (source, ref, mix, LPF, PI, PE, TX path, FTW) from a single stream.

Parameters:
- NUM_CH, 18, number of valid log channels (select codes 0..NUM_CH-1); mask bits at or above NUM_CH are ignored.
- SETTLE, 2, clock cycles from a select change until the mux output reflects the new channel (select register plus output register).
- DWELL_W, 16, width of the per-channel sample count.

Ports:
- clk  in  1  system clock, 125 MHz.
- rst_n  in  1  reset.
- start  in  1  single-cycle pulse that begins a sweep; ignored while busy.
- stop  in  1  abort request; takes effect at the next clock edge.
- continuous  in  1  1 = restart the sweep after the last channel until stop; sampled at start.
- ch_mask  in  32  channel enable mask; bit n enables select code n; latched at start.
- dwell  in  DWELL_W  samples captured per channel; latched at start; 0 is treated as 1.
- sel_out  out  5  log-select code driven to the mux.
- S_AXIS_LOG_tdata  in  32  mux output data.
- M_AXIS_tdata  out  32  captured sample.
- M_AXIS_tuser  out  5  channel code of this sample.
- M_AXIS_tlast  out  1  marks the last sample of a sweep.
- M_AXIS_tvalid  out  1  beat valid.
- M_AXIS_tready  in  1  downstream ready.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a non-continuous sweep completes.
- overflow  out  1  sticky; set when a sample is dropped; cleared by start.

Behaviour:
- Interface: one clock (clk); rst_n is asynchronous, active-low.
- Reset values: sel_out 0, all M_AXIS outputs 0, busy 0, done 0, overflow 0, state IDLE, all counters 0.
- States:
  - IDLE:
    - start=1 with masked mask (ch_mask & ((1<<NUM_CH)-1)) == 0 → DONE.
    - start=1 otherwise → SETTLE; sel_out ← lowest enabled channel; settle counter ← SETTLE.
  - SETTLE: counter decrements each cycle; at 0 → CAPTURE.
  - CAPTURE:
    - One sample captured per cycle; sample counter counts to dwell.
    - After the last sample of a channel, if a higher enabled channel exists: sel_out ← next enabled channel (ascending) in the same edge → SETTLE.
    - Otherwise, if continuous: sel_out ← lowest enabled channel → SETTLE.
    - Otherwise → DONE.
  - DONE: done=1 for exactly one cycle → IDLE.
- Capture timing: for the edge that accepts start, or a channel switch, at edge k, the first sample is registered at edge k+SETTLE+1, with M_AXIS_tvalid high from that edge.
- Capture gaps: samples within a channel are contiguous, one per cycle; there is a SETTLE-cycle gap at every channel switch.
- Output register: single entry. On a capture edge:
  - If tvalid=0 or tready=1: load tdata, tuser=sel_out, tlast; tvalid=1.
  - Otherwise keep the held beat, drop the new sample, set overflow. The sample counter still advances, so the scan schedule never stalls.
- Held beats: tvalid clears on tready when no new sample is loaded in the same edge. A held beat's tdata/tuser/tlast stay stable until accepted.
- tlast: 1 only on the final sample of the final enabled channel of each sweep, including each lap in continuous mode.
- stop: from any non-IDLE state, go to IDLE at the next edge. A pending beat stays valid until accepted. done is not pulsed. sel_out holds its last value.
- Simultaneous start and stop in IDLE: stop wins and the sweep does not start.
- start while busy: ignored, and ch_mask/dwell/continuous are not re-latched.
- rst_n asserted mid-sweep: all state returns to the reset values immediately, and any beat in flight is lost.
- Counters: sample counter width is DWELL_W with no wrap, since compare-to-dwell ends the channel. Channel search uses priority encoding over the latched mask above the current code.

Test Plan:
- Single sweep: ch_mask=0b101, dwell=3, SETTLE=2, tready=1, start at edge 0 → beats at edges 3,4,5 with tuser=0, then 8,9,10 with tuser=2. tlast only on the edge-10 beat. done pulses one cycle later; busy then falls.
- Data integrity: drive S_AXIS_LOG_tdata = {27'd0, sel delayed 2 cycles}, mask=0x3FFFF, dwell=1 → every beat has tdata == tuser, covering all 18 channels.
- Backpressure: mask=0b1, dwell=4, tready=0 → first beat held stable with tdata of the edge-3 sample, overflow=1, and done still pulses on schedule. A subsequent start clears overflow.
- Continuous mode: mask=0b110, dwell=2, continuous=1 → tuser sequence 1,1,2,2,1,1,2,2…, tlast on every 4th beat. stop → busy low next cycle and no done pulse.
- Edge cases:
  - mask=0, or mask only above bit 17 → done one cycle after start, no beats.
  - dwell=0 → behaves as dwell=1.
  - start while busy → no effect.
- Reset mid-capture: assert rst_n low during CAPTURE → tvalid, busy, sel_out and overflow are 0 immediately. A new start after reset runs a clean sweep.
